// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the seg_scan_ctrl display controller:
//   - state_t      : conversion FSM encoding (ST_IDLE, ST_CONV)
//   - SLOT_*       : scan slot indices (ones, tens/nibble 1, hundreds/nibble 2)
//   - CONV_ITERS   : shift-add-3 iterations per conversion (one per value bit)
//   - MODE_*       : display mode encodings sampled with load
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_ONES = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_HUND = 2'd2;

  localparam int CONV_ITERS = 9;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// One combinational shift-add-3 (double dabble) iteration over a 3-digit BCD
// accumulator.
// Ports:
//   bcd_in   in  12  current BCD accumulator {hund, tens, ones}
//   shift_in in   1  next binary bit, MSB first
//   bcd_out  out 12  accumulator after add-3 correction and left shift
// -----------------------------------------------------------------------------
module bcd_dabble_step (
  input  logic [11:0] bcd_in,
  input  logic        shift_in,
  output logic [11:0] bcd_out
);

  logic [11:0] adj;

  // A nibble >= 5 would exceed 9 after doubling, so pre-correct it by +3.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_nibble
      assign adj[4*gi +: 4] = (bcd_in[4*gi +: 4] >= 4'd5) ? bcd_in[4*gi +: 4] + 4'd3
                                                          : bcd_in[4*gi +: 4];
    end
  endgenerate

  // The top bit shifted out is always zero for inputs up to 511.
  assign bcd_out = 12'({adj, shift_in});

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Samples a 9-bit value on load, converts it to three digits (iterative BCD in
// decimal mode, nibble split in hex mode, both taking 9 cycles), holds them in
// a display register and time-multiplexes them onto a shared digit bus.
// Parameters:
//   REFRESH_DIV  clock cycles per scan slot (2 .. 2^20)
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   value      in   9  binary value to display
//   mode       in   1  0 = hex, 1 = decimal (sampled with load)
//   load       in   1  capture request, honoured when idle or on the final
//                      conversion edge
//   busy       out  1  conversion in progress
//   done       out  1  one-cycle pulse when the display register is updated
//   digit      out  4  nibble for the active slot
//   anode_sel  out  3  one-hot active slot (bit0 ones, bit1 tens, bit2 hund)
// Build option:
//   SEG_SCAN_BLANK_LEAD_EN  blank leading-zero hundreds/tens slots
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] value,
  input  logic       mode,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit,
  output logic [2:0] anode_sel
);

  localparam int             CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]     ITER_LAST = 4'(CONV_ITERS - 1);

  // ---------------------------------------------------------------------------
  // Conversion FSM and datapath
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [3:0]  iter_reg;
  logic        mode_reg;
  logic [8:0]  val_reg;
  logic [8:0]  shift_reg;
  logic [11:0] bcd_reg;
  logic [11:0] disp_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [11:0] bcd_next;
  logic [11:0] conv_result;
  logic        last_iter;
  logic        accept;

  bcd_dabble_step u_step (
    .bcd_in   (bcd_reg),
    .shift_in (shift_reg[8]),
    .bcd_out  (bcd_next)
  );

  always_comb begin
    last_iter   = (state_reg == ST_CONV) && (iter_reg == ITER_LAST);
    // The final conversion edge behaves as idle for a new request, which gives
    // back-to-back conversions every 9 cycles.
    accept      = load && ((state_reg == ST_IDLE) || last_iter);
    // Hex split is {000, v[8]}, v[7:4], v[3:0}, i.e. the raw value zero-extended.
    conv_result = (mode_reg == MODE_HEX) ? {3'b000, val_reg} : bcd_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      iter_reg  <= '0;
      mode_reg  <= MODE_HEX;
      val_reg   <= '0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      disp_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last_iter;
      if (last_iter) begin
        disp_reg <= conv_result;
      end

      if (accept) begin
        state_reg <= ST_CONV;
        busy_reg  <= 1'b1;
        val_reg   <= value;
        shift_reg <= value;
        mode_reg  <= mode;
        bcd_reg   <= '0;
        iter_reg  <= '0;
      end else if (last_iter) begin
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end else if (state_reg == ST_CONV) begin
        bcd_reg   <= bcd_next;
        shift_reg <= {shift_reg[7:0], 1'b0};
        iter_reg  <= iter_reg + 4'd1;
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

  // ---------------------------------------------------------------------------
  // Display scanning (free-running, independent of the FSM)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       slot_reg;
  logic [1:0]       slot_next;
  logic [3:0]       digit_reg;
  logic [3:0]       digit_next;
  logic [2:0]       anode_reg;
  logic [2:0]       anode_next;
  logic             wrap;

  // Outputs are computed from the slot that will be active after this edge so
  // digit and anode_sel switch together; digit also follows a fresh commit.
  always_comb begin
    wrap      = (cnt_reg == CNT_LAST);
    slot_next = slot_reg;
    if (wrap) begin
      slot_next = (slot_reg == SLOT_HUND) ? SLOT_ONES : slot_reg + 2'd1;
    end

    digit_next = 4'd0;
    anode_next = 3'b000;
    case (slot_next)
      SLOT_ONES: begin
        digit_next = disp_reg[3:0];
        anode_next = 3'b001;
      end
      SLOT_TENS: begin
        digit_next = disp_reg[7:4];
        anode_next = 3'b010;
      end
      SLOT_HUND: begin
        digit_next = disp_reg[11:8];
        anode_next = 3'b100;
      end
      default: begin
        digit_next = 4'd0;
        anode_next = 3'b000;
      end
    endcase

`ifdef SEG_SCAN_BLANK_LEAD_EN
    // Leading-zero blanking: the slot still runs for its full time, only the
    // anode is suppressed.
    if ((slot_next == SLOT_HUND) && (disp_reg[11:8] == 4'd0)) begin
      anode_next = 3'b000;
    end
    if ((slot_next == SLOT_TENS) && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0)) begin
      anode_next = 3'b000;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      slot_reg  <= SLOT_ONES;
      digit_reg <= 4'd0;
      anode_reg <= 3'b001;
    end else begin
      cnt_reg   <= wrap ? '0 : cnt_reg + CNT_W'(1);
      slot_reg  <= slot_next;
      digit_reg <= digit_next;
      anode_reg <= anode_next;
    end
  end

  assign digit     = digit_reg;
  assign anode_sel = anode_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed self-checking bench for seg_scan_ctrl with REFRESH_DIV = 4.
// Displayed digits are recovered by watching anode_sel/digit for three full
// slot periods; a blanked slot reads as 0, which is what it must hold.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] value = '0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic [2:0] anode_sel;

  int tests_run = 0;
  int tests_failed = 0;

  seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .mode      (mode),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .digit     (digit),
    .anode_sel (anode_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle load; returns at the negedge following the capture edge.
  task automatic start_load(input logic [8:0] v, input logic m);
    @(negedge clk);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Count busy cycles until done is seen; returns at the negedge showing done.
  task automatic wait_done(output int nbusy);
    bit got;
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_digits(output logic [11:0] d);
    d = 12'h000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (anode_sel)
        3'b001:  d[3:0]  = digit;
        3'b010:  d[7:4]  = digit;
        3'b100:  d[11:8] = digit;
        default: ;
      endcase
    end
  endtask

  task automatic run_conv(input logic [8:0] v, input logic m, output logic [11:0] d);
    int nb;
    start_load(v, m);
    wait_done(nb);
    @(negedge clk);
    read_digits(d);
    $display("[TB] conv value=%0d mode=%0d digits=%03h", v, m, d);
  endtask

  initial begin
    logic [11:0] d;
    logic [11:0] exp_d;
    int          nb;
    int          ndone;
    int          nzero;
    int          nones;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_anode", {29'd0, anode_sel}, 32'b001);
    check("rst_digit", {28'd0, digit}, 32'd0);

    // ---------------- scan sequence ----------------
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [2:0] exp_a;
      case ((k / 4) % 3)
        0:       exp_a = 3'b001;
        1:       exp_a = 3'b010;
        default: exp_a = 3'b100;
      endcase
      check($sformatf("scan_anode_k%0d", k), {29'd0, anode_sel}, {29'd0, exp_a});
      @(negedge clk);
    end
    $display("[TB] scan sequence checked over 24 cycles");

    // ---------------- decimal 511 ----------------
    start_load(9'd511, MODE_DEC);
    wait_done(nb);
    check("dec511_busy_cycles", nb, 32'd9);
    check("dec511_done", {31'd0, done}, 32'd1);
    check("dec511_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("dec511_done_single", {31'd0, done}, 32'd0);
    read_digits(d);
    check("dec511_digits", {20'd0, d}, 32'h511);
    $display("[TB] conv value=511 mode=1 digits=%03h busy_cycles=%0d", d, nb);

    // ---------------- hex cases ----------------
    run_conv(9'd511, MODE_HEX, d);
    check("hex511_digits", {20'd0, d}, 32'h1FF);
    run_conv(9'd165, MODE_HEX, d);
    check("hex165_digits", {20'd0, d}, 32'h0A5);
    run_conv(9'd256, MODE_HEX, d);
    check("hex256_digits", {20'd0, d}, 32'h100);

    // ---------------- load while busy is ignored ----------------
    @(negedge clk);
    value = 9'd37; mode = MODE_DEC; load = 1'b1;
    @(negedge clk); load = 1'b0;                    // after E0
    @(negedge clk); value = 9'd200; load = 1'b1;    // sampled at E2
    @(negedge clk); load = 1'b0;
    wait_done(nb);
    check("busyload_busy_cycles", nb, 32'd7);
    @(negedge clk);
    read_digits(d);
    check("busyload_digits", {20'd0, d}, 32'h037);
    check("busyload_idle", {31'd0, busy}, 32'd0);
    $display("[TB] conv value=37 with ignored load 200 digits=%03h", d);

    // ---------------- back-to-back load at E9 ----------------
    @(negedge clk);
    value = 9'd123; mode = MODE_DEC; load = 1'b1;
    @(negedge clk); load = 1'b0;                    // after E0
    repeat (8) @(negedge clk);                      // after E8
    check("b2b_no_early_done", {31'd0, done}, 32'd0);
    value = 9'd200; load = 1'b1;                    // sampled at E9
    @(negedge clk); load = 1'b0;                    // after E9
    check("b2b_done_first", {31'd0, done}, 32'd1);
    check("b2b_busy_held", {31'd0, busy}, 32'd1);
    @(negedge clk);
    wait_done(nb);
    check("b2b_busy_cycles", nb, 32'd8);
    @(negedge clk);
    read_digits(d);
    check("b2b_digits", {20'd0, d}, 32'h200);
    $display("[TB] back-to-back 123 then 200 digits=%03h", d);

    // ---------------- reset mid-conversion ----------------
    start_load(9'd300, MODE_DEC);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_done",  {31'd0, done}, 32'd0);
    check("midrst_anode", {29'd0, anode_sel}, 32'b001);
    check("midrst_digit", {28'd0, digit}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);
    read_digits(d);
    check("midrst_display", {20'd0, d}, 32'h000);
    $display("[TB] reset mid-conversion digits=%03h", d);

    // ---------------- leading-zero blanking (value 7, decimal) ----------------
    run_conv(9'd7, MODE_DEC, d);
    check("dec7_digits", {20'd0, d}, 32'h007);
    nzero = 0;
    nones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (anode_sel == 3'b000) nzero++;
      if (anode_sel == 3'b001) nones++;
    end
    check("blank_ones_slots", nones, 32'd4);
`ifdef SEG_SCAN_BLANK_LEAD_EN
    check("blank_zero_slots", nzero, 32'd8);
`else
    check("blank_zero_slots", nzero, 32'd0);
`endif

    // ---------------- exhaustive decimal ----------------
    for (int v = 0; v < 512; v++) begin
      run_conv(9'(v), MODE_DEC, d);
      exp_d = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      check($sformatf("dec_exh_%0d", v), {20'd0, d}, {20'd0, exp_d});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Sequential display controller for the hex/decimal value display. It samples a 9-bit value on request and converts it to three digits: either an iterative shift-add-3 BCD conversion or a hex nibble split. The digits are held in a display register. The controller time-multiplexes those three digits onto a shared digit bus with a one-hot digit select, ahead of the seven-segment decoder and the board anodes.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit slot stays active; legal range 2 to 2^20.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `value`  in  9  binary value to display, range 0–511.
- `mode`  in  1  display mode: 0 = hex, 1 = decimal. Sampled with `load`.
- `load`  in  1  single-cycle request to capture `value` and `mode`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  single-cycle pulse when new digits are committed to the display register.
- `digit`  out  4  nibble for the currently selected slot.
- `anode_sel`  out  3  one-hot slot select, active-high: bit 0 = ones, bit 1 = tens/nibble 1, bit 2 = hundreds/nibble 2.

## Operation
- **FSM states**
  - IDLE → CONV when `load`=1 (sampled at the clock edge). `value` and `mode` are captured; the BCD accumulator and iteration count are cleared.
  - CONV → IDLE on the edge where the iteration count equals 8.
- **Load while busy:** `load` in CONV is ignored, with no queuing.
- **Decimal conversion:** a 12-bit BCD accumulator and a 9-bit shift register. On each CONV edge:
  - add 3 to every BCD nibble ≥ 5;
  - then shift {BCD, shift} left by one.
  - 9 iterations in total. The hundreds digit never exceeds 5.
- **Hex split:** digits are {3'b000, v[8]}, v[7:4], v[3:0]. It follows the same CONV timing so latency is mode-independent.
- **Commit:** on the final CONV edge, the three digits are written to the display register and `done` pulses. The display register changes only at commit or reset.
- **Scanning** runs continuously, independent of the FSM:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the wrap, the slot advances 0→1→2→0.
  - `anode_sel` = one-hot(slot); `digit` = display nibble for that slot, taken from the registered display.
  - During CONV, the previous value stays on display.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, display register 0x000, slot 0, `anode_sel`=3'b001, `digit`=0, refresh counter 0.
- **Reset mid-conversion:** the conversion is abandoned and all state returns to reset values. No `done` pulse.
- **Conversion latency:**
  - `load` sampled at edge E0.
  - `busy`=1 after E0 through E9.
  - The commit and `done`=1 are registered at E9; `busy` falls at E9.
  - `load` at E9 is accepted, giving back-to-back conversions every 9 cycles (E9 counts as IDLE).
- **Scan outputs:** `digit` and `anode_sel` are registered and change together, exactly once per REFRESH_DIV cycles. A commit is visible from the next edge in whatever slot is active; slot timing is unaffected.

## Configuration
- Macro: `SEG_SCAN_BLANK_LEAD_EN`.
- **Defined:** leading-zero blanking.
  - The hundreds slot drives `anode_sel`=3'b000 when the hundreds digit is 0.
  - The tens slot drives 3'b000 when both hundreds and tens are 0.
  - Ones is never blanked.
  - Slot timing is unchanged; `digit` still carries the nibble.
- **Undefined:** all three slots are always driven.

## Structure
- Shared package `seg_scan_pkg`:
  - FSM state encoding (IDLE, CONV);
  - slot constants (SLOT_ONES=0, SLOT_TENS=1, SLOT_HUND=2);
  - `CONV_ITERS`=9;
  - `MODE_HEX`=0, `MODE_DEC`=1.
- Sub-module `bcd_dabble_step`: combinational single iteration, taking the 12-bit BCD and 1-bit shift-in and returning the next 12-bit BCD. Instantiated once inside the CONV datapath.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all outputs at their reset values immediately (asynchronous); `anode_sel`=3'b001, `digit`=0.
- **Decimal 511:**
  - `value`=511, `mode`=1, `load` pulse → `busy` high for exactly 9 cycles, `done` pulse at E9.
  - Scanning then shows ones=1, tens=1, hund=5.
- **Hex 511:** `value`=511, `mode`=0 → after 9 cycles the digits are F, F, 1.
- **Exhaustive decimal:** for all values 0–511, 100·hund + 10·tens + ones = value, and each digit ≤ 9.
- **Busy load:**
  - `load` with `value`=200 two cycles after a `load` with `value`=37 → only 37 is displayed.
  - A second `load` at E9 is accepted and shows 200 after 9 more cycles.
- **Scan, `REFRESH_DIV`=4:**
  - `anode_sel` sequence is 001, 010, 100, repeating, each held 4 cycles.
  - With `SEG_SCAN_BLANK_LEAD_EN` and `value`=7 in decimal mode, the tens and hundreds slots drive 000.
